// File: rtl/masked_pkg.sv
// rtl/masked_pkg.sv - shared sizing helpers for the DOM masked AND gadget
package masked_pkg;

    localparam int CNT_W_DEFAULT = 16;

    // Number of fresh random bits one D-share multiplication consumes.
    function automatic int rand_w(input int d);
        return (d * (d - 1)) / 2;
    endfunction

    // Position of the random bit shared by share pair (i,j), i<j, in rin.
    function automatic int pair_idx(input int i, input int j, input int d);
        return i * d - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/dom_cross_term.sv
// rtl/dom_cross_term.sv - one registered DOM product term (a_i & b_j) ^ r
(* keep_hierarchy = "yes" *)
module dom_cross_term (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_a,
    input  logic i_b,
    input  logic i_r,
    output logic o_q
);

    logic r_q;

    // Glitch barrier: the remasked partial product is captured before any recombination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= i_clr ? 1'b0 : ((i_a & i_b) ^ i_r);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/masked_and_dom.sv
// rtl/masked_and_dom.sv - D-share DOM-indep masked AND, 2-stage pipeline; option MASKED_AND_CLR_IDLE_EN
module masked_and_dom
    import masked_pkg::*;
#(
    parameter  int D      = 2,
    parameter  int CNT_W  = CNT_W_DEFAULT,
    localparam int RAND_W = rand_w(D)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [D-1:0]      ina,
    input  logic [D-1:0]      inb,
    input  logic [RAND_W-1:0] rin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [D-1:0]      out,
    output logic [CNT_W-1:0]  op_cnt
);

    logic             w_advance;
    logic             w_en1;
    logic             w_clr1;
    logic             w_en2;
    logic             w_clr2;
    logic [D*D-1:0]   w_t;
    logic [D-1:0]     w_out_d;
    logic             r_v1;
    logic             r_out_valid;
    logic [D-1:0]     r_out;
    logic [CNT_W-1:0] r_op_cnt;

    // Single global stall: everything moves only when the output slot is free or draining.
    assign w_advance = !r_out_valid | out_ready;
    assign in_ready  = w_advance;

`ifdef MASKED_AND_CLR_IDLE_EN
    // Idle slots overwrite data with zeros so no stale shares linger.
    assign w_en1  = w_advance;
    assign w_clr1 = !in_valid;
    assign w_en2  = w_advance;
    assign w_clr2 = !r_v1;
`else
    // Idle slots leave data untouched; only the valid bits move.
    assign w_en1  = w_advance & in_valid;
    assign w_clr1 = 1'b0;
    assign w_en2  = w_advance & r_v1;
    assign w_clr2 = 1'b0;
`endif

    for (genvar gi = 0; gi < D; gi++) begin : g_row
        for (genvar gj = 0; gj < D; gj++) begin : g_col
            if (gi == gj) begin : g_inner
                dom_cross_term u_term (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .i_en  (w_en1),
                    .i_clr (w_clr1),
                    .i_a   (ina[gi]),
                    .i_b   (inb[gj]),
                    .i_r   (1'b0),
                    .o_q   (w_t[gi*D+gj])
                );
            end else begin : g_cross
                localparam int IDX = (gi < gj) ? pair_idx(gi, gj, D) : pair_idx(gj, gi, D);
                dom_cross_term u_term (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .i_en  (w_en1),
                    .i_clr (w_clr1),
                    .i_a   (ina[gi]),
                    .i_b   (inb[gj]),
                    .i_r   (rin[IDX]),
                    .o_q   (w_t[gi*D+gj])
                );
            end
        end
    end

    // Output share i recombines row i of the registered terms.
    always_comb begin
        w_out_d = '0;
        for (int i = 0; i < D; i++) begin
            for (int j = 0; j < D; j++) begin
                w_out_d[i] = w_out_d[i] ^ w_t[i*D+j];
            end
        end
    end

    // Valid pipeline: v1 tracks stage 1, out_valid tracks the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_advance) begin
            r_v1        <= in_valid;
            r_out_valid <= r_v1;
        end
    end

    // Output share register, the second glitch barrier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_en2) begin
            r_out <= w_clr2 ? '0 : w_out_d;
        end
    end

    // Completed hand-off counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_op_cnt <= r_op_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign op_cnt    = r_op_cnt;

endmodule
